// File: rtl/stopwatch_counter.sv
// stopwatch_counter: four-digit BCD mm:ss timekeeping core.
// Counts on tick_1hz while running, toggles run/pause on btn_pause rising
// edges, and lets the user load individual digits while the adj switch is on.
// All outputs come straight from flops.
module stopwatch_counter #(
   parameter int SEC_T_MAX = 5,
   parameter int MIN_T_MAX = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_1hz,
   input  logic       tick_adj,
   input  logic       btn_reset,
   input  logic       btn_pause,
   input  logic       adj,
   input  logic [1:0] sel,
   input  logic [3:0] num,
   output logic [3:0] sec_u,
   output logic [3:0] sec_t,
   output logic [3:0] min_u,
   output logic [3:0] min_t,
   output logic       running,
   output logic       adj_blink,
   output logic       wrap
);

   typedef enum logic [1:0] {
      ST_PAUSE  = 2'd0,
      ST_RUN    = 2'd1,
      ST_ADJUST = 2'd2
   } state_t;

   localparam logic [3:0] UNIT_MAX  = 4'd9;
   localparam logic [3:0] SEC_T_LIM = 4'(SEC_T_MAX);
   localparam logic [3:0] MIN_T_LIM = 4'(MIN_T_MAX);

   state_t     state_q, state_d;
   logic       btn_pause_q, btn_pause_d;
   logic [3:0] sec_u_q, sec_u_d;
   logic [3:0] sec_t_q, sec_t_d;
   logic [3:0] min_u_q, min_u_d;
   logic [3:0] min_t_q, min_t_d;
   logic       running_q, running_d;
   logic       adj_blink_q, adj_blink_d;
   logic       wrap_q, wrap_d;

   logic       pause_edge_s;
   logic       do_load_s;
   logic       do_count_s;
   logic [3:0] digit_max_s;
   logic [3:0] num_clamp_s;

   // Rising edge of the debounced pause button (previous level resets to 1).
   assign pause_edge_s = btn_pause & ~btn_pause_q;
   assign btn_pause_d  = btn_pause;

   // Load and count qualifiers use the state held before the edge.
   assign do_load_s  = (state_q == ST_ADJUST) & tick_adj;
   assign do_count_s = (state_q == ST_RUN) & ~adj & tick_1hz;

   // Next-state: adj overrides everything, pause edges toggle PAUSE/RUN.
   always_comb begin
      state_d = state_q;
      if (adj) begin
         state_d = ST_ADJUST;
      end else begin
         case (state_q)
            ST_PAUSE: begin
               if (pause_edge_s) state_d = ST_RUN;
               else              state_d = ST_PAUSE;
            end
            ST_RUN: begin
               if (pause_edge_s) state_d = ST_PAUSE;
               else              state_d = ST_RUN;
            end
            ST_ADJUST: state_d = ST_PAUSE;
            default:   state_d = ST_PAUSE;
         endcase
      end
   end

   // Clamp the requested adjust value to the limit of the selected digit.
   always_comb begin
      digit_max_s = UNIT_MAX;
      case (sel)
         2'd0:    digit_max_s = UNIT_MAX;
         2'd1:    digit_max_s = SEC_T_LIM;
         2'd2:    digit_max_s = UNIT_MAX;
         2'd3:    digit_max_s = MIN_T_LIM;
         default: digit_max_s = UNIT_MAX;
      endcase
      if (num > digit_max_s) num_clamp_s = digit_max_s;
      else                   num_clamp_s = num;
   end

   // Digit update: clear, then adjust load, then BCD count with ripple carry.
   always_comb begin
      sec_u_d = sec_u_q;
      sec_t_d = sec_t_q;
      min_u_d = min_u_q;
      min_t_d = min_t_q;
      wrap_d  = 1'b0;
      if (btn_reset) begin
         sec_u_d = 4'd0;
         sec_t_d = 4'd0;
         min_u_d = 4'd0;
         min_t_d = 4'd0;
      end else if (do_load_s) begin
         case (sel)
            2'd0:    sec_u_d = num_clamp_s;
            2'd1:    sec_t_d = num_clamp_s;
            2'd2:    min_u_d = num_clamp_s;
            2'd3:    min_t_d = num_clamp_s;
            default: sec_u_d = sec_u_q;
         endcase
      end else if (do_count_s) begin
         // ">=" keeps any corrupted digit heading back into range.
         if (sec_u_q >= UNIT_MAX) begin
            sec_u_d = 4'd0;
            if (sec_t_q >= SEC_T_LIM) begin
               sec_t_d = 4'd0;
               if (min_u_q >= UNIT_MAX) begin
                  min_u_d = 4'd0;
                  if (min_t_q >= MIN_T_LIM) begin
                     min_t_d = 4'd0;
                     wrap_d  = 1'b1;
                  end else begin
                     min_t_d = min_t_q + 4'd1;
                  end
               end else begin
                  min_u_d = min_u_q + 4'd1;
               end
            end else begin
               sec_t_d = sec_t_q + 4'd1;
            end
         end else begin
            sec_u_d = sec_u_q + 4'd1;
         end
      end else begin
         sec_u_d = sec_u_q;
      end
   end

   // Status flags: running tracks the new state; blink restarts on ADJUST entry.
   always_comb begin
      running_d = (state_d == ST_RUN);
      if ((state_q == ST_ADJUST) && (state_d == ST_ADJUST)) begin
         adj_blink_d = adj_blink_q ^ tick_adj;
      end else begin
         adj_blink_d = 1'b0;
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_PAUSE;
         btn_pause_q <= 1'b1;
         sec_u_q     <= 4'd0;
         sec_t_q     <= 4'd0;
         min_u_q     <= 4'd0;
         min_t_q     <= 4'd0;
         running_q   <= 1'b0;
         adj_blink_q <= 1'b0;
         wrap_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         btn_pause_q <= btn_pause_d;
         sec_u_q     <= sec_u_d;
         sec_t_q     <= sec_t_d;
         min_u_q     <= min_u_d;
         min_t_q     <= min_t_d;
         running_q   <= running_d;
         adj_blink_q <= adj_blink_d;
         wrap_q      <= wrap_d;
      end
   end

   assign sec_u     = sec_u_q;
   assign sec_t     = sec_t_q;
   assign min_u     = min_u_q;
   assign min_t     = min_t_q;
   assign running   = running_q;
   assign adj_blink = adj_blink_q;
   assign wrap      = wrap_q;

endmodule
